// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

    // Fetch FSM states, 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_HALT  = 2'b10
    } fetch_state_e;

    // addi $0,$0,0 filler word; stops fetch when FETCH_HALT_EN is defined
    localparam logic [31:0] HALT_WORD = 32'h2000_0000;

    // Instruction field bit positions
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int SH_HI  = 10;
    localparam int SH_LO  = 6;
    localparam int FN_HI  = 5;
    localparam int FN_LO  = 0;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    // Opcodes seen in the fetch stream
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_ADDI  = 6'h08;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/instr_field_decode.sv
// rtl/instr_field_decode.sv - combinational split of an instruction word into fields
//
// Ports:
//   instr     in  32  instruction word
//   opcode    out 6   instr[31:26]
//   rs        out 5   instr[25:21]
//   rt        out 5   instr[20:16]
//   rd        out 5   instr[15:11]
//   shamt     out 5   instr[10:6]
//   funct     out 6   instr[5:0]
//   imm_sext  out 32  instr[15:0] sign-extended
module instr_field_decode
    import fetch_pkg::*;
(
    input  logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [31:0] imm_sext
);

    assign opcode   = instr[OPC_HI:OPC_LO];
    assign rs       = instr[RS_HI:RS_LO];
    assign rt       = instr[RT_HI:RT_LO];
    assign rd       = instr[RD_HI:RD_LO];
    assign shamt    = instr[SH_HI:SH_LO];
    assign funct    = instr[FN_HI:FN_LO];
    assign imm_sext = sext16(instr[IMM_HI:IMM_LO]);

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC register, instruction memory read and valid/ready hand-off to decode
//
// Optional feature macro: FETCH_HALT_EN (stop fetching on HALT_WORD).
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   start           leave IDLE and begin fetching
//   imem_addr       word address to instruction memory (the pc register)
//   imem_rd         combinational memory read data for imem_addr
//   redirect_valid  load redirect_addr into pc, discard pending word
//   redirect_addr   redirect target word address
//   out_valid       instr_out/pc_out hold a fetched word
//   out_ready       decode accepts the word when out_valid && out_ready
//   instr_out       registered instruction word
//   pc_out          address instr_out was fetched from
//   opcode..funct   fields of instr_out
//   imm_sext        instr_out[15:0] sign-extended
//   halted          fetch stopped on HALT_WORD
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rd,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic [5:0]        opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [5:0]        funct,
    output logic [31:0]       imm_sext,
    output logic              halted
);

    fetch_state_e      state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [ADDR_W-1:0] pc_out_nxt;
    logic [DATA_W-1:0] instr_nxt;
    logic              valid_nxt;
    logic              halted_nxt;
    logic              cap;

    // A new word may be captured when the output slot is empty or being drained
    assign cap = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            out_valid <= 1'b0;
            instr_out <= '0;
            pc_out    <= '0;
            halted    <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            out_valid <= valid_nxt;
            instr_out <= instr_nxt;
            pc_out    <= pc_out_nxt;
            halted    <= halted_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        valid_nxt  = out_valid;
        instr_nxt  = instr_out;
        pc_out_nxt = pc_out;
        halted_nxt = halted;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Redirect beats capture: the held word is dropped even if accepted now
                if (redirect_valid) begin
                    pc_nxt     = redirect_addr;
                    valid_nxt  = 1'b0;
                    halted_nxt = 1'b0;
                end else if (cap) begin
`ifdef FETCH_HALT_EN
                    if (imem_rd == DATA_W'(HALT_WORD)) begin
                        // pc stays on the halt address so a later dump shows where fetch stopped
                        valid_nxt  = 1'b0;
                        halted_nxt = 1'b1;
                        state_nxt  = ST_HALT;
                    end else begin
                        instr_nxt  = imem_rd;
                        pc_out_nxt = pc;
                        valid_nxt  = 1'b1;
                        pc_nxt     = pc + ADDR_W'(1);
                    end
`else
                    instr_nxt  = imem_rd;
                    pc_out_nxt = pc;
                    valid_nxt  = 1'b1;
                    pc_nxt     = pc + ADDR_W'(1);
`endif
                end
            end
            ST_HALT: begin
                if (redirect_valid) begin
                    pc_nxt     = redirect_addr;
                    valid_nxt  = 1'b0;
                    halted_nxt = 1'b0;
                    state_nxt  = ST_FETCH;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign imem_addr = pc;

    instr_field_decode u_decode (
        .instr    (instr_out[31:0]),
        .opcode   (opcode),
        .rs       (rs),
        .rt       (rt),
        .rd       (rd),
        .shamt    (shamt),
        .funct    (funct),
        .imm_sext (imm_sext)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rd;
    logic        redirect_valid;
    logic [7:0]  redirect_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr_out;
    logic [7:0]  pc_out;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] imm_sext;
    logic        halted;

    logic [31:0] mem [0:255];

    int n_assert;
    int n_fail;

`ifdef FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    // Reference model: fetch pointer, held word and run/halt status
    bit         m_run;
    bit         m_valid;
    bit         m_halted;
    logic [7:0] m_fetch;
    logic [7:0] m_pc_out;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .imem_addr      (imem_addr),
        .imem_rd        (imem_rd),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .instr_out      (instr_out),
        .pc_out         (pc_out),
        .opcode         (opcode),
        .rs             (rs),
        .rt             (rt),
        .rd             (rd),
        .shamt          (shamt),
        .funct          (funct),
        .imm_sext       (imm_sext),
        .halted         (halted)
    );

    assign imem_rd = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run    = 1'b0;
        m_valid  = 1'b0;
        m_halted = 1'b0;
        m_fetch  = 8'h00;
        m_pc_out = 8'h00;
    endtask

    task automatic model_step(input logic st, input logic rdy, input logic rv, input logic [7:0] ra);
        if (!m_run) begin
            if (st) m_run = 1'b1;
        end else if (rv) begin
            m_fetch  = ra;
            m_valid  = 1'b0;
            m_halted = 1'b0;
        end else if (!m_halted && (!m_valid || rdy)) begin
            if (HALT_EN && mem[m_fetch] == 32'h2000_0000) begin
                m_valid  = 1'b0;
                m_halted = 1'b1;
            end else begin
                m_valid  = 1'b1;
                m_pc_out = m_fetch;
                m_fetch  = m_fetch + 8'd1;
            end
        end
    endtask

    task automatic check_model();
        logic [31:0] w;
        chk("valid", 32'(out_valid), 32'(m_valid));
        chk("imem_addr", 32'(imem_addr), 32'(m_fetch));
        chk("halted", 32'(halted), 32'(m_halted));
        if (m_valid) begin
            w = mem[m_pc_out];
            chk("pc_out", 32'(pc_out), 32'(m_pc_out));
            chk("instr_out", instr_out, w);
            chk("opcode", 32'(opcode), 32'(w[31:26]));
            chk("rs", 32'(rs), 32'(w[25:21]));
            chk("rt", 32'(rt), 32'(w[20:16]));
            chk("rd", 32'(rd), 32'(w[15:11]));
            chk("shamt", 32'(shamt), 32'(w[10:6]));
            chk("funct", 32'(funct), 32'(w[5:0]));
            chk("imm_sext", imm_sext, {{16{w[15]}}, w[15:0]});
        end
    endtask

    // One clock: check against model, apply inputs, advance model at the edge
    task automatic cyc(input logic st, input logic rdy, input logic rv, input logic [7:0] ra);
        check_model();
        start          = st;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_addr  = ra;
        @(posedge clk);
        model_step(st, rdy, rv, ra);
        #1;
        start          = 1'b0;
        redirect_valid = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h2000_0000;
        mem[0]     = 32'h2001_0003;
        mem[1]     = 32'h2002_0009;
        mem[2]     = 32'h0022_1020;
        mem[3]     = 32'h0022_1824;
        mem[4]     = 32'h0022_2025;
        mem[5]     = 32'h2020_0002;
        mem[8'h80] = 32'h2001_FFFF;

        rst            = 1'b1;
        start          = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = 8'h00;
        model_reset();
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'h00);
        chk("rst_instr", instr_out, 32'h0);
        chk("rst_pc_out", 32'(pc_out), 32'h00);
        chk("rst_halted", 32'(halted), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // IDLE: nothing fetched without start
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b1, 8'h33);
        chk("idle_addr", 32'(imem_addr), 32'h00);
        chk("idle_valid", 32'(out_valid), 32'd0);

        // start at edge N, first word after N+1
        cyc(1'b1, 1'b1, 1'b0, 8'h00);
        chk("lat_n_valid", 32'(out_valid), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        chk("w0_instr", instr_out, 32'h2001_0003);
        chk("w0_pc", 32'(pc_out), 32'h00);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        chk("w1_instr", instr_out, 32'h2002_0009);
        chk("w1_pc", 32'(pc_out), 32'h01);

        // stall three cycles on addr 1
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 8'h00);
            chk("stall_instr", instr_out, 32'h2002_0009);
            chk("stall_pc", 32'(pc_out), 32'h01);
            chk("stall_addr", 32'(imem_addr), 32'h02);
        end
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        chk("w2_instr", instr_out, 32'h0022_1020);
        chk("w2_pc", 32'(pc_out), 32'h02);
        chk("w2_opcode", 32'(opcode), 32'h00);
        chk("w2_rs", 32'(rs), 32'd1);
        chk("w2_rt", 32'(rt), 32'd2);
        chk("w2_rd", 32'(rd), 32'd2);
        chk("w2_funct", 32'(funct), 32'h20);

        // redirect to 4 while stalled on addr 2, with ready high on the redirect cycle
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b1, 8'h04);
        chk("redir_valid", 32'(out_valid), 32'd0);
        chk("redir_addr", 32'(imem_addr), 32'h04);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        chk("w4_instr", instr_out, 32'h0022_2025);
        chk("w4_pc", 32'(pc_out), 32'h04);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        chk("w5_pc", 32'(pc_out), 32'h05);
        chk("w5_imm", imm_sext, 32'h0000_0002);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);

`ifdef FETCH_HALT_EN
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_valid", 32'(out_valid), 32'd0);
        chk("halt_addr", 32'(imem_addr), 32'h06);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        chk("halt_hold", 32'(halted), 32'd1);
        cyc(1'b0, 1'b1, 1'b1, 8'h00);
        chk("halt_exit", 32'(halted), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        chk("resume_instr", instr_out, 32'h2001_0003);
`else
        chk("w6_instr", instr_out, 32'h2000_0000);
        chk("w6_pc", 32'(pc_out), 32'h06);
        begin
            int budget;
            budget = 0;
            while (!(out_valid && pc_out == 8'hFF) && budget < 300) begin
                cyc(1'b0, 1'b1, 1'b0, 8'h00);
                budget++;
            end
            chk("reach_ff", 32'(pc_out), 32'h0000_00FF);
        end
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        chk("wrap_pc", 32'(pc_out), 32'h00);
        chk("wrap_instr", instr_out, 32'h2001_0003);
`endif

        // negative immediate
        cyc(1'b0, 1'b1, 1'b1, 8'h80);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        chk("neg_imm", imm_sext, 32'hFFFF_FFFF);

        // randomized backpressure and redirects
        for (int i = 0; i < 400; i++) begin
            logic       r_rdy;
            logic       r_rv;
            logic [7:0] r_ra;
            r_rdy = ($urandom_range(0, 3) != 0);
            r_rv  = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 3))
                0:       r_ra = 8'h80;
                1:       r_ra = 8'(($urandom_range(0, 3)) + 252);
                default: r_ra = 8'($urandom_range(0, 7));
            endcase
            cyc(1'($urandom_range(0, 1)), r_rdy, r_rv, r_ra);
        end

        // asynchronous reset mid-stream
        cyc(1'b0, 1'b1, 1'b1, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_addr", 32'(imem_addr), 32'h00);
        chk("arst_halted", 32'(halted), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00);
        chk("post_rst_idle", 32'(out_valid), 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        chk("restart_instr", instr_out, 32'h2001_0003);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        check_model();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
